// File: rtl/fmdll_lock_ctrl.sv
// rtl/fmdll_lock_ctrl.sv - FMDLL N/M divider counters, delay-code stepping and lock sequencer
module fmdll_lock_ctrl #(
    parameter int CODE_W    = 6,
    parameter int CODE_INIT = 32,
    parameter int LOCK_CNT  = 8,
    parameter int N_RST     = 8,
    parameter int M_RST     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_edge,
    input  logic              pd_early,
    input  logic              pd_late,
    input  logic              cfg_valid,
    input  logic [3:0]        cfg_n,
    input  logic [1:0]        cfg_m,
    output logic              cfg_ready,
    output logic [3:0]        N,
    output logic [1:0]        M,
    output logic [3:0]        N_counter,
    output logic [1:0]        M_counter,
    output logic              DIV_N,
    output logic              DIV_M,
    output logic [CODE_W-1:0] dly_code,
    output logic              locked,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACQ    = 2'd1,
        S_TRACK  = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    localparam logic [CODE_W-1:0] CODE_RST = CODE_W'(CODE_INIT);
    localparam logic [CODE_W-1:0] CODE_MAX = {CODE_W{1'b1}};
    localparam logic [CODE_W-1:0] CODE_ONE = CODE_W'(1);
    localparam logic [7:0]        LOCK_TGT = 8'(LOCK_CNT);

    state_t            state_q, state_d;
    logic [3:0]        n_q, n_d, n_cnt_q, n_cnt_d;
    logic [1:0]        m_q, m_d, m_cnt_q, m_cnt_d;
    logic [CODE_W-1:0] dly_q, dly_d;
    logic              locked_q, locked_d;
    logic [7:0]        lock_cnt_q, lock_cnt_d;
    logic              last_corr_q, last_corr_d;
    logic              last_dir_q, last_dir_d;
    logic              pend_valid_q, pend_valid_d;
    logic [3:0]        pend_n_q, pend_n_d;
    logic [1:0]        pend_m_q, pend_m_d;
    logic              ready_q, ready_d;
    logic              ready_ret_q, ready_ret_d;

    logic fe, apply, accept, corr, dir_up;

    // Register all sequencer state; reset drops any pending configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            n_q          <= 4'(N_RST);
            m_q          <= 2'(M_RST);
            n_cnt_q      <= 4'd1;
            m_cnt_q      <= 2'd1;
            dly_q        <= CODE_RST;
            locked_q     <= 1'b0;
            lock_cnt_q   <= 8'd0;
            last_corr_q  <= 1'b0;
            last_dir_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_n_q     <= 4'd1;
            pend_m_q     <= 2'd1;
            ready_q      <= 1'b1;
            ready_ret_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            m_q          <= m_d;
            n_cnt_q      <= n_cnt_d;
            m_cnt_q      <= m_cnt_d;
            dly_q        <= dly_d;
            locked_q     <= locked_d;
            lock_cnt_q   <= lock_cnt_d;
            last_corr_q  <= last_corr_d;
            last_dir_q   <= last_dir_d;
            pend_valid_q <= pend_valid_d;
            pend_n_q     <= pend_n_d;
            pend_m_q     <= pend_m_d;
            ready_q      <= ready_d;
            ready_ret_q  <= ready_ret_d;
        end
    end

    // Next-state: counters, frame-end phase step, lock FSM, then config apply/accept overrides.
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        m_d          = m_q;
        n_cnt_d      = n_cnt_q;
        m_cnt_d      = m_cnt_q;
        dly_d        = dly_q;
        locked_d     = locked_q;
        lock_cnt_d   = lock_cnt_q;
        last_corr_d  = last_corr_q;
        last_dir_d   = last_dir_q;
        pend_valid_d = pend_valid_q;
        pend_n_d     = pend_n_q;
        pend_m_d     = pend_m_q;
        ready_d      = ready_q;
        ready_ret_d  = 1'b0;

        // The edge that leaves IDLE only starts frame 1; it is never a frame end.
        fe     = ext_edge && (state_q != S_IDLE) && (m_cnt_q == m_q);
        apply  = pend_valid_q && ext_edge && (fe || (state_q == S_IDLE));
        accept = cfg_valid && ready_q;
        corr   = pd_early ^ pd_late;
        dir_up = pd_early;

        if (state_q == S_IDLE) begin
            n_cnt_d = 4'd1;
            m_cnt_d = 2'd1;
            if (ext_edge) begin
                state_d     = S_ACQ;
                lock_cnt_d  = 8'd0;
                last_corr_d = 1'b0;
            end
        end else begin
            // A reference edge realigns the period count ahead of the natural wrap.
            n_cnt_d = (ext_edge || (n_cnt_q >= n_q)) ? 4'd1 : n_cnt_q + 4'd1;
            if (ext_edge) begin
                m_cnt_d = (m_cnt_q >= m_q) ? 2'd1 : m_cnt_q + 2'd1;
            end
            if (fe) begin
                if (corr) begin
                    if (dir_up) begin
                        dly_d = (dly_q == CODE_MAX) ? dly_q : dly_q + CODE_ONE;
                    end else begin
                        dly_d = (dly_q == '0) ? dly_q : dly_q - CODE_ONE;
                    end
                    last_corr_d = 1'b1;
                    last_dir_d  = dir_up;
                end else begin
                    last_corr_d = 1'b0;
                end
                case (state_q)
                    S_ACQ: begin
                        if (!corr || (last_corr_q && (last_dir_q != dir_up))) begin
                            state_d    = S_TRACK;
                            lock_cnt_d = 8'd0;
                        end
                    end
                    S_TRACK: begin
                        if (corr) begin
                            lock_cnt_d = 8'd0;
                        end else if (lock_cnt_q + 8'd1 == LOCK_TGT) begin
                            state_d    = S_LOCKED;
                            locked_d   = 1'b1;
                            lock_cnt_d = 8'd0;
                        end else begin
                            lock_cnt_d = lock_cnt_q + 8'd1;
                        end
                    end
                    S_LOCKED: begin
                        if (corr && last_corr_q && (last_dir_q == dir_up)) begin
                            state_d    = S_TRACK;
                            locked_d   = 1'b0;
                            lock_cnt_d = 8'd0;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // Applying a config restarts acquisition and suppresses this frame's phase step.
        if (apply) begin
            n_d          = pend_n_q;
            m_d          = pend_m_q;
            n_cnt_d      = 4'd1;
            m_cnt_d      = 2'd1;
            state_d      = S_ACQ;
            locked_d     = 1'b0;
            lock_cnt_d   = 8'd0;
            dly_d        = dly_q;
            last_corr_d  = 1'b0;
            last_dir_d   = last_dir_q;
            pend_valid_d = 1'b0;
            ready_ret_d  = 1'b1;
        end

        // The slot reopens one cycle after apply; accept cannot coincide with a pending apply.
        if (accept) begin
            pend_valid_d = 1'b1;
            pend_n_d     = (cfg_n == 4'd0) ? 4'd1 : cfg_n;
            pend_m_d     = (cfg_m == 2'd0) ? 2'd1 : cfg_m;
            ready_d      = 1'b0;
        end else if (ready_ret_q) begin
            ready_d = 1'b1;
        end
    end

    assign cfg_ready = ready_q;
    assign N         = n_q;
    assign M         = m_q;
    assign N_counter = n_cnt_q;
    assign M_counter = m_cnt_q;
    assign DIV_N     = (n_cnt_q == n_q);
    assign DIV_M     = (m_cnt_q == m_q);
    assign dly_code  = dly_q;
    assign locked    = locked_q;
    assign state     = state_q;

endmodule

// File: tb/tb_fmdll_lock_ctrl.sv
// tb/tb_fmdll_lock_ctrl.sv - directed self-checking bench for fmdll_lock_ctrl
module tb_fmdll_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ext_edge, pd_early, pd_late, cfg_valid;
    logic [3:0] cfg_n;
    logic [1:0] cfg_m;
    logic       cfg_ready;
    logic [3:0] N, N_counter;
    logic [1:0] M, M_counter;
    logic       DIV_N, DIV_M;
    logic [5:0] dly_code;
    logic       locked;
    logic [1:0] state;

    int tests = 0;
    int fails = 0;

    fmdll_lock_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .ext_edge  (ext_edge),
        .pd_early  (pd_early),
        .pd_late   (pd_late),
        .cfg_valid (cfg_valid),
        .cfg_n     (cfg_n),
        .cfg_m     (cfg_m),
        .cfg_ready (cfg_ready),
        .N         (N),
        .M         (M),
        .N_counter (N_counter),
        .M_counter (M_counter),
        .DIV_N     (DIV_N),
        .DIV_M     (DIV_M),
        .dly_code  (dly_code),
        .locked    (locked),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic period(input logic e, input logic l, input int nclk);
        ext_edge = 1'b1;
        pd_early = e;
        pd_late  = l;
        tick();
        ext_edge = 1'b0;
        pd_early = 1'b0;
        pd_late  = 1'b0;
        repeat (nclk - 1) tick();
    endtask

    task automatic frame(input logic e, input logic l);
        period(e, l, 8);
        period(1'b0, 1'b0, 8);
    endtask

    initial begin
        rst = 1'b1;
        ext_edge = 0; pd_early = 0; pd_late = 0; cfg_valid = 0; cfg_n = 0; cfg_m = 0;
        #12;
        chk("rst_N", N, 8);
        chk("rst_M", M, 2);
        chk("rst_Ncnt", N_counter, 1);
        chk("rst_Mcnt", M_counter, 1);
        chk("rst_DIVN", DIV_N, 0);
        chk("rst_DIVM", DIV_M, 0);
        chk("rst_dly", dly_code, 32);
        chk("rst_locked", locked, 0);
        chk("rst_state", state, 0);
        chk("rst_ready", cfg_ready, 1);
        rst = 1'b0;

        repeat (3) tick();
        chk("idle_Ncnt_hold", N_counter, 1);
        chk("idle_state", state, 0);

        // First edge: IDLE -> ACQ, then N_counter walks 1..8
        ext_edge = 1'b1;
        tick();
        ext_edge = 1'b0;
        chk("acq_state", state, 1);
        chk("p1_Ncnt_1", N_counter, 1);
        chk("p1_Mcnt", M_counter, 1);
        for (int k = 2; k <= 8; k++) begin
            tick();
            chk("p1_Ncnt", N_counter, k);
            chk("p1_DIVN", DIV_N, (k == 8) ? 1 : 0);
        end
        period(1'b0, 1'b0, 8);
        chk("p2_Mcnt", M_counter, 2);
        chk("p2_DIVM", DIV_M, 1);
        chk("p2_Ncnt", N_counter, 8);

        // Early corrections in ACQ, then an opposite one moves to TRACK
        frame(1'b1, 1'b0);
        chk("early1_dly", dly_code, 33);
        chk("early1_state", state, 1);
        frame(1'b1, 1'b0);
        chk("early2_dly", dly_code, 34);
        frame(1'b0, 1'b1);
        chk("late_dly", dly_code, 33);
        chk("late_state", state, 2);
        for (int f = 1; f <= 7; f++) frame(1'b0, 1'b0);
        chk("win7_locked", locked, 0);
        chk("win7_state", state, 2);
        frame(1'b0, 1'b0);
        chk("win8_locked", locked, 1);
        chk("win8_state", state, 3);
        chk("win8_dly", dly_code, 33);

        // Two same-direction corrections drop lock
        frame(1'b0, 1'b1);
        chk("lk_late1_state", state, 3);
        chk("lk_late1_dly", dly_code, 32);
        frame(1'b0, 1'b1);
        chk("lk_late2_state", state, 2);
        chk("lk_late2_locked", locked, 0);
        chk("lk_late2_dly", dly_code, 31);

        // Mid-frame config request, applied only at the next frame end
        period(1'b0, 1'b0, 8);
        cfg_valid = 1'b1; cfg_n = 4'd5; cfg_m = 2'd3;
        tick();
        cfg_valid = 1'b0;
        chk("cfg_ready_low", cfg_ready, 0);
        chk("cfg_N_held", N, 8);
        period(1'b0, 1'b0, 8);
        chk("cfg_N_mid", N, 8);
        chk("cfg_M_mid", M, 2);
        chk("cfg_ready_mid", cfg_ready, 0);
        ext_edge = 1'b1; pd_early = 1'b1;
        tick();
        ext_edge = 1'b0; pd_early = 1'b0;
        chk("app_N", N, 5);
        chk("app_M", M, 3);
        chk("app_Ncnt", N_counter, 1);
        chk("app_Mcnt", M_counter, 1);
        chk("app_state", state, 1);
        chk("app_locked", locked, 0);
        chk("app_dly", dly_code, 31);
        chk("app_ready", cfg_ready, 0);
        tick();
        chk("app_ready_back", cfg_ready, 1);
        repeat (3) tick();
        chk("n5_Ncnt", N_counter, 5);
        chk("n5_DIVN", DIV_N, 1);
        chk("n5_DIVM", DIV_M, 0);

        // Zero request clamps to N=1, M=1
        cfg_valid = 1'b1; cfg_n = 4'd0; cfg_m = 2'd0;
        tick();
        cfg_valid = 1'b0;
        period(1'b0, 1'b0, 5);
        period(1'b0, 1'b0, 5);
        chk("m3_Mcnt", M_counter, 3);
        chk("m3_DIVM", DIV_M, 1);
        ext_edge = 1'b1;
        tick();
        chk("clamp_N", N, 1);
        chk("clamp_M", M, 1);
        chk("clamp_DIVN", DIV_N, 1);
        chk("clamp_state", state, 1);

        // Every edge is now a frame end: late held saturates the code at 0
        pd_late = 1'b1;
        repeat (31) tick();
        chk("sat_dly_0", dly_code, 0);
        repeat (4) tick();
        chk("sat_dly_hold", dly_code, 0);
        chk("sat_state", state, 1);
        pd_late = 1'b0;
        tick();
        ext_edge = 1'b0;
        chk("trk_state", state, 2);

        // Reset during TRACK with a pending config
        cfg_valid = 1'b1; cfg_n = 4'd7; cfg_m = 2'd2;
        tick();
        cfg_valid = 1'b0;
        chk("pend_ready", cfg_ready, 0);
        #2 rst = 1'b1;
        #1;
        chk("ar_N", N, 8);
        chk("ar_M", M, 2);
        chk("ar_Ncnt", N_counter, 1);
        chk("ar_dly", dly_code, 32);
        chk("ar_state", state, 0);
        chk("ar_locked", locked, 0);
        chk("ar_ready", cfg_ready, 1);
        #3 rst = 1'b0;
        ext_edge = 1'b1;
        tick();
        ext_edge = 1'b0;
        chk("post_state", state, 1);
        chk("post_N", N, 8);
        chk("post_M", M, 2);
        chk("post_ready", cfg_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
